seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx.sv | 184 ++++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial MSB-first pattern transmitter with repeat and idle-high gaps
//
// Loads a pattern of programmable length on i_start and shifts it out one
// bit per clock, repeated i_repeat+1 times with GAP idle-high cycles between
// repetitions. All outputs are registered from the next-state values.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   i_start    start request (sampled only while idle)
//   i_pattern  pattern bits, active field i_pattern[len-1:0]
//   i_len      pattern length (0 = empty job, >WIDTH clamped to WIDTH)
//   i_repeat   repetitions minus one
//   i_stop     abort request (honoured while shifting or in a gap)
//   o_seq      serial data, 1 when not transmitting
//   o_valid    o_seq carries a pattern bit
//   o_busy     high in every state except idle
//   o_done     one-cycle completion pulse
//   o_aborted  one-cycle pulse alongside o_done when the job was stopped

module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  input  logic [CNT_W-1:0] i_repeat,
  input  logic             i_stop,
  output logic             o_seq,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_seq;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic [1:0]       w_state_nx;
  logic [WIDTH-1:0] w_pat_nx;
  logic [LEN_W-1:0] w_len_nx;
  logic [LEN_W-1:0] w_idx_nx;
  logic [CNT_W-1:0] w_rep_nx;
  logic [CNT_W-1:0] w_rep_cnt_nx;
  logic [GAP_W-1:0] w_gap_cnt_nx;
  logic             w_stop_hit;
  logic [LEN_W-1:0] w_len_clamp;
  logic [WIDTH-1:0] w_shift_nx;

  assign w_len_clamp = (int'(i_len) > WIDTH) ? LEN_W'(WIDTH) : i_len;

  // Bit selected for the next cycle; shifting avoids an index-width mismatch
  // between LEN_W and log2(WIDTH).
  assign w_shift_nx = w_pat_nx >> w_idx_nx;

  always_comb begin
    w_state_nx   = r_state;
    w_pat_nx     = r_pat;
    w_len_nx     = r_len;
    w_idx_nx     = r_idx;
    w_rep_nx     = r_rep;
    w_rep_cnt_nx = r_rep_cnt;
    w_gap_cnt_nx = r_gap_cnt;
    w_stop_hit   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_pat_nx     = i_pattern;
          w_len_nx     = w_len_clamp;
          w_rep_nx     = i_repeat;
          w_rep_cnt_nx = '0;
          if (w_len_clamp == '0) begin
            w_state_nx = S_DONE;
          end else begin
            w_idx_nx   = w_len_clamp - LEN_W'(1);
            w_state_nx = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        if (i_stop) begin
          w_state_nx = S_DONE;
          w_stop_hit = 1'b1;
        end else if (r_idx == '0) begin
          // rep_cnt only advances while below rep, so it never wraps even
          // when rep is all-ones.
          if (r_rep_cnt < r_rep) begin
            w_rep_cnt_nx = r_rep_cnt + CNT_W'(1);
            if (GAP == 0) begin
              w_idx_nx   = r_len - LEN_W'(1);
              w_state_nx = S_SHIFT;
            end else begin
              w_gap_cnt_nx = GAP_W'(GAP - 1);
              w_state_nx   = S_GAP;
            end
          end else begin
            w_state_nx = S_DONE;
          end
        end else begin
          w_idx_nx = r_idx - LEN_W'(1);
        end
      end

      S_GAP: begin
        if (i_stop) begin
          w_state_nx = S_DONE;
          w_stop_hit = 1'b1;
        end else if (r_gap_cnt == '0) begin
          w_idx_nx   = r_len - LEN_W'(1);
          w_state_nx = S_SHIFT;
        end else begin
          w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        // S_DONE: single cycle, start requests here are dropped
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_rep     <= '0;
      r_rep_cnt <= '0;
      r_gap_cnt <= '0;
      r_seq     <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pat     <= w_pat_nx;
      r_len     <= w_len_nx;
      r_idx     <= w_idx_nx;
      r_rep     <= w_rep_nx;
      r_rep_cnt <= w_rep_cnt_nx;
      r_gap_cnt <= w_gap_cnt_nx;
      // Outputs are decoded from the next state so they line up with it.
      r_seq     <= (w_state_nx == S_SHIFT) ? w_shift_nx[0] : 1'b1;
      r_valid   <= (w_state_nx == S_SHIFT);
      r_busy    <= (w_state_nx != S_IDLE);
      r_done    <= (w_state_nx == S_DONE);
      r_aborted <= w_stop_hit;
    end
  end

  assign o_seq     = r_seq;
  assign o_valid   = r_valid;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_aborted = r_aborted;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx

module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_pattern;
  logic [3:0] i_len;
  logic [3:0] i_repeat;
  logic       i_stop;
  logic       o_seq;
  logic       o_valid;
  logic       o_busy;
  logic       o_done;
  logic       o_aborted;

  int checks = 0;
  int errors = 0;

  // downstream "01" detector over valid bits
  logic prev_bit = 1'b1;
  int   det_cnt  = 0;

  // expected vector order: {seq, valid, busy, done, aborted}
  localparam logic [4:0] IDLE  = 5'b10000;
  localparam logic [4:0] GAPV  = 5'b10100;
  localparam logic [4:0] DONE  = 5'b10110;
  localparam logic [4:0] ABORT = 5'b10111;

  seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_pattern (i_pattern),
    .i_len     (i_len),
    .i_repeat  (i_repeat),
    .i_stop    (i_stop),
    .o_seq     (o_seq),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_aborted (o_aborted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid) begin
      if (prev_bit == 1'b0 && o_seq == 1'b1) det_cnt = det_cnt + 1;
      prev_bit = o_seq;
    end
  end

  task automatic step_chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    @(negedge clk);
    obs = {o_seq, o_valid, o_busy, o_done, o_aborted};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] bitv(input logic b);
    return {b, 4'b1100};
  endfunction

  initial begin
    logic [7:0] pv;
    int         det_base;

    rst = 1'b1; i_start = 1'b0; i_pattern = '0; i_len = '0; i_repeat = '0; i_stop = 1'b0;
    step_chk("reset_a", IDLE);
    step_chk("reset_b", IDLE);
    rst = 1'b0;
    step_chk("idle", IDLE);

    // 1: 4'b0101, single shot
    det_base = det_cnt;
    i_pattern = 8'h05; i_len = 4'd4; i_repeat = 4'd0; i_start = 1'b1;
    step_chk("t1_b3", bitv(1'b0));
    i_start = 1'b0;
    step_chk("t1_b2", bitv(1'b1));
    step_chk("t1_b1", bitv(1'b0));
    step_chk("t1_b0", bitv(1'b1));
    step_chk("t1_done", DONE);
    step_chk("t1_idle", IDLE);
    checks++;
    assert (det_cnt - det_base === 2) else begin
      errors++;
      $error("FAIL t1_detect observed=%0d expected=2", det_cnt - det_base);
    end

    // 2: 2'b10 three times with one-cycle gaps
    i_pattern = 8'h02; i_len = 4'd2; i_repeat = 4'd2; i_start = 1'b1;
    step_chk("t2_c1", bitv(1'b1));
    i_start = 1'b0;
    step_chk("t2_c2", bitv(1'b0));
    step_chk("t2_c3", GAPV);
    step_chk("t2_c4", bitv(1'b1));
    step_chk("t2_c5", bitv(1'b0));
    step_chk("t2_c6", GAPV);
    step_chk("t2_c7", bitv(1'b1));
    step_chk("t2_c8", bitv(1'b0));
    step_chk("t2_done", DONE);
    step_chk("t2_idle", IDLE);

    // 3a: empty job
    i_pattern = 8'hFF; i_len = 4'd0; i_repeat = 4'd3; i_start = 1'b1;
    step_chk("t3a_done", DONE);
    i_start = 1'b0;
    step_chk("t3a_idle", IDLE);

    // 3b: length 12 clamps to 8
    pv = 8'hA5;
    i_pattern = pv; i_len = 4'd12; i_repeat = 4'd0; i_start = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      step_chk($sformatf("t3b_b%0d", i), bitv(pv[i]));
      i_start = 1'b0;
    end
    step_chk("t3b_done", DONE);
    step_chk("t3b_idle", IDLE);

    // 4: stop while bit 3 is on the line
    i_pattern = 8'hC3; i_len = 4'd8; i_repeat = 4'd0; i_start = 1'b1;
    step_chk("t4_b1", bitv(1'b1));
    i_start = 1'b0;
    step_chk("t4_b2", bitv(1'b1));
    step_chk("t4_b3", bitv(1'b0));
    i_stop = 1'b1;
    step_chk("t4_abort", ABORT);
    i_stop = 1'b0;
    step_chk("t4_idle", IDLE);

    // 5: start pulse and input changes mid-job are ignored
    pv = 8'h96;
    i_pattern = pv; i_len = 4'd8; i_repeat = 4'd0; i_start = 1'b1;
    step_chk("t5_b7", bitv(pv[7]));
    i_start = 1'b0;
    step_chk("t5_b6", bitv(pv[6]));
    i_start = 1'b1; i_pattern = 8'hFF; i_len = 4'd3; i_repeat = 4'd5;
    step_chk("t5_b5", bitv(pv[5]));
    i_start = 1'b0;
    for (int i = 4; i >= 0; i--) step_chk($sformatf("t5_b%0d", i), bitv(pv[i]));
    step_chk("t5_done", DONE);
    step_chk("t5_idle_a", IDLE);
    step_chk("t5_idle_b", IDLE);

    // 6: reset mid-shift, then start+stop together in idle
    i_pattern = 8'h5A; i_len = 4'd8; i_repeat = 4'd0; i_start = 1'b1;
    step_chk("t6_b7", bitv(1'b0));
    i_start = 1'b0;
    step_chk("t6_b6", bitv(1'b1));
    rst = 1'b1;
    step_chk("t6_rst", IDLE);
    rst = 1'b0;
    step_chk("t6_no_done", IDLE);
    pv = 8'h09;
    i_pattern = pv; i_len = 4'd4; i_repeat = 4'd1; i_start = 1'b1; i_stop = 1'b1;
    step_chk("t6_r0_b3", bitv(pv[3]));
    i_start = 1'b0; i_stop = 1'b0;
    for (int i = 2; i >= 0; i--) step_chk($sformatf("t6_r0_b%0d", i), bitv(pv[i]));
    step_chk("t6_gap", GAPV);
    for (int i = 3; i >= 0; i--) step_chk($sformatf("t6_r1_b%0d", i), bitv(pv[i]));
    step_chk("t6_done", DONE);
    step_chk("t6_idle", IDLE);

    // 7: all-ones repeat yields 16 repetitions of a single 0 bit
    i_pattern = 8'h00; i_len = 4'd1; i_repeat = 4'hF; i_start = 1'b1;
    for (int r = 0; r < 16; r++) begin
      step_chk($sformatf("t7_bit%0d", r), bitv(1'b0));
      i_start = 1'b0;
      if (r != 15) step_chk($sformatf("t7_gap%0d", r), GAPV);
    end
    step_chk("t7_done", DONE);
    step_chk("t7_idle", IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
